// File: rtl/dpram_pkg.sv
// Shared types and helpers for the parametrised dual-port RAM.
package dpram_pkg;

   localparam int unsigned RDW_READ_FIRST  = 0;
   localparam int unsigned RDW_WRITE_FIRST = 1;

   // Widest data word the parity helper accepts; callers zero-extend.
   localparam int unsigned PAR_MAX_W = 1024;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } dpram_state_t;

   // Even-parity bit: makes the total count of ones in {bit, data} even.
   function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/dpram_init_ctrl.sv
// Post-reset clear sweep controller: walks every address once, then opens the ports.
module dpram_init_ctrl
   import dpram_pkg::*;
#(
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   output logic              sweep_we_c,
   output logic [ADDR_W-1:0] sweep_addr,
   output logic              ready
);

   dpram_state_t      state, state_next;
   logic [ADDR_W-1:0] addr_next;
   logic              ready_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= INIT;
         sweep_addr <= '0;
         ready      <= 1'b0;
      end else begin
         state      <= state_next;
         sweep_addr <= addr_next;
         ready      <= ready_next;
      end
   end

   always_comb begin
      state_next = state;
      addr_next  = sweep_addr;
      ready_next = ready;
      sweep_we_c = 1'b0;
      case (state)
         INIT: begin
            sweep_we_c = !rst;
            addr_next  = sweep_addr + ADDR_W'(1);
            // Last word of the sweep hands over to the ports on the same edge.
            if (sweep_addr == {ADDR_W{1'b1}}) begin
               state_next = RUN;
               ready_next = 1'b1;
            end
         end
         RUN: begin
            ready_next = 1'b1;
         end
         default: begin
            state_next = INIT;
         end
      endcase
   end

endmodule

// File: rtl/param_dual_port_ram.sv
// True dual-port synchronous RAM with collision policy and post-reset clear sweep.
// Optional per-word even parity when DPRAM_PARITY_EN is defined.
module param_dual_port_ram
   import dpram_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 6,
   parameter int unsigned RDW_MODE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_a,
   input  logic              en_b,
   input  logic              we_a,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] data_a,
   input  logic [DATA_W-1:0] data_b,
   output logic [DATA_W-1:0] q_a,
   output logic [DATA_W-1:0] q_b,
   output logic              ready,
   output logic              collision,
   output logic              par_err_a,
   output logic              par_err_b
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef DPRAM_PARITY_EN
   localparam int unsigned MEM_W = DATA_W + 1;
`else
   localparam int unsigned MEM_W = DATA_W;
`endif
   localparam logic WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

   logic [MEM_W-1:0]  mem [DEPTH];
   logic              sweep_we_c;
   logic [ADDR_W-1:0] sweep_addr;
   logic              wr_a, wr_b, same_addr;
   logic [MEM_W-1:0]  wword_a, wword_b, rd_word_a, rd_word_b;

   dpram_init_ctrl #(
      .ADDR_W (ADDR_W)
   ) u_init_ctrl (
      .clk        (clk),
      .rst        (rst),
      .sweep_we_c (sweep_we_c),
      .sweep_addr (sweep_addr),
      .ready      (ready)
   );

   assign wr_a      = ready && en_a && we_a;
   assign wr_b      = ready && en_b && we_b;
   assign same_addr = (addr_a == addr_b);
   assign rd_word_a = mem[addr_a];
   assign rd_word_b = mem[addr_b];

`ifdef DPRAM_PARITY_EN
   assign wword_a = {even_parity(PAR_MAX_W'(data_a)), data_a};
   assign wword_b = {even_parity(PAR_MAX_W'(data_b)), data_b};
`else
   assign wword_a = data_a;
   assign wword_b = data_b;
`endif

   // Storage: sweep owns the array in INIT; port A wins a same-address write.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (sweep_we_c) begin
            mem[sweep_addr] <= '0;
         end else begin
            if (wr_b && !(wr_a && same_addr)) mem[addr_b] <= wword_b;
            if (wr_a)                         mem[addr_a] <= wword_a;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_a       <= '0;
         q_b       <= '0;
         collision <= 1'b0;
      end else begin
         collision <= wr_a && wr_b && same_addr;
         if (ready && en_a) q_a <= (we_a && WRITE_FIRST) ? data_a : rd_word_a[DATA_W-1:0];
         if (ready && en_b) q_b <= (we_b && WRITE_FIRST) ? data_b : rd_word_b[DATA_W-1:0];
      end
   end

`ifdef DPRAM_PARITY_EN
   // Write-first returns freshly encoded data, so only stored words can flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         par_err_a <= 1'b0;
         par_err_b <= 1'b0;
      end else begin
         if (ready && en_a)
            par_err_a <= !(we_a && WRITE_FIRST) &&
                         (even_parity(PAR_MAX_W'(rd_word_a[DATA_W-1:0])) != rd_word_a[DATA_W]);
         if (ready && en_b)
            par_err_b <= !(we_b && WRITE_FIRST) &&
                         (even_parity(PAR_MAX_W'(rd_word_b[DATA_W-1:0])) != rd_word_b[DATA_W]);
      end
   end
`else
   assign par_err_a = 1'b0;
   assign par_err_b = 1'b0;
`endif

endmodule

// File: tb/tb_param_dual_port_ram.sv
// Directed, table-driven bench for param_dual_port_ram (default 8x64 build).
module tb_param_dual_port_ram;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 6;
   localparam int unsigned RDW    = 0;

   logic              clk = 1'b0;
   logic              rst;
   logic              en_a, en_b, we_a, we_b;
   logic [ADDR_W-1:0] addr_a, addr_b;
   logic [DATA_W-1:0] data_a, data_b;
   logic [DATA_W-1:0] q_a, q_b;
   logic              ready, collision, par_err_a, par_err_b;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       en_a, we_a;
      logic [5:0] addr_a;
      logic [7:0] data_a;
      logic       en_b, we_b;
      logic [5:0] addr_b;
      logic [7:0] data_b;
      logic       chk_qa;
      logic [7:0] exp_qa;
      logic       chk_qb;
      logic [7:0] exp_qb;
      logic       exp_col;
   } vec_t;

   vec_t vecs [14];

   param_dual_port_ram #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .RDW_MODE (RDW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en_a      (en_a),
      .en_b      (en_b),
      .we_a      (we_a),
      .we_b      (we_b),
      .addr_a    (addr_a),
      .addr_b    (addr_b),
      .data_a    (data_a),
      .data_b    (data_b),
      .q_a       (q_a),
      .q_b       (q_b),
      .ready     (ready),
      .collision (collision),
      .par_err_a (par_err_a),
      .par_err_b (par_err_b)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ea, input logic wa, input logic [5:0] aa, input logic [7:0] da,
                        input logic eb, input logic wb, input logic [5:0] ab, input logic [7:0] db);
      en_a = ea; we_a = wa; addr_a = aa; data_a = da;
      en_b = eb; we_b = wb; addr_b = ab; data_b = db;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00);
   endtask

   // Releases reset and counts edges until ready; ready must not rise early.
   task automatic wait_ready(input string name);
      int cnt = 0;
      rst = 1'b0;
      while (!ready && cnt < 200) begin
         tick();
         cnt++;
      end
      chk(name, 32'(cnt), 32'd64);
   endtask

   initial begin
      vecs[0]  = '{1, 1, 6'd1,  8'h33, 1, 1, 6'd2,  8'h44, 1, (RDW == 1) ? 8'h33 : 8'h00, 1, (RDW == 1) ? 8'h44 : 8'h00, 0};
      vecs[1]  = '{1, 0, 6'd2,  8'h00, 1, 0, 6'd1,  8'h00, 1, 8'h44, 1, 8'h33, 0};
      vecs[2]  = '{1, 1, 6'd3,  8'h55, 1, 1, 6'd3,  8'h66, 0, 8'h00, 0, 8'h00, 1};
      vecs[3]  = '{0, 0, 6'd0,  8'h00, 0, 0, 6'd0,  8'h00, 0, 8'h00, 0, 8'h00, 0};
      vecs[4]  = '{1, 0, 6'd3,  8'h00, 0, 0, 6'd0,  8'h00, 1, 8'h55, 0, 8'h00, 0};
      vecs[5]  = '{1, 1, 6'd2,  8'h77, 1, 0, 6'd2,  8'h00, 1, (RDW == 1) ? 8'h77 : 8'h44, 1, 8'h44, 0};
      vecs[6]  = '{1, 0, 6'd2,  8'h00, 1, 0, 6'd2,  8'h00, 1, 8'h77, 1, 8'h77, 0};
      vecs[7]  = '{1, 1, 6'd10, 8'hAA, 1, 1, 6'd11, 8'hBB, 0, 8'h00, 0, 8'h00, 0};
      vecs[8]  = '{0, 0, 6'd10, 8'h00, 1, 0, 6'd11, 8'h00, 1, (RDW == 1) ? 8'hAA : 8'h00, 1, 8'hBB, 0};
      vecs[9]  = '{1, 0, 6'd10, 8'h00, 0, 0, 6'd0,  8'h00, 1, 8'hAA, 1, 8'hBB, 0};
      vecs[10] = '{1, 1, 6'd0,  8'h01, 1, 1, 6'd63, 8'hFF, 0, 8'h00, 0, 8'h00, 0};
      vecs[11] = '{1, 0, 6'd63, 8'h00, 1, 0, 6'd0,  8'h00, 1, 8'hFF, 1, 8'h01, 0};
      vecs[12] = '{0, 1, 6'd10, 8'h12, 0, 1, 6'd11, 8'h34, 1, 8'hFF, 1, 8'h01, 0};
      vecs[13] = '{1, 0, 6'd10, 8'h00, 1, 0, 6'd11, 8'h00, 1, 8'hAA, 1, 8'hBB, 0};

      rst = 1'b1;
      idle();
      tick();
      tick();
      chk("rst_q_a", 32'(q_a), 32'h0);
      chk("rst_q_b", 32'(q_b), 32'h0);
      chk("rst_ready", 32'(ready), 32'h0);
      chk("rst_collision", 32'(collision), 32'h0);
      wait_ready("ready_latency_first");

      // Garbage preload, then a fresh reset must clear it.
      drive(1, 1, 6'd0,  8'hDE, 1, 1, 6'd31, 8'hAD);
      tick();
      drive(1, 1, 6'd63, 8'hBE, 0, 0, 6'd0,  8'h00);
      tick();
      drive(1, 0, 6'd0,  8'h00, 1, 0, 6'd31, 8'h00);
      tick();
      chk("preload_q_a", 32'(q_a), 32'hDE);
      chk("preload_q_b", 32'(q_b), 32'hAD);
      idle();
      rst = 1'b1;
      tick();
      chk("rerst_ready", 32'(ready), 32'h0);
      chk("rerst_q_a", 32'(q_a), 32'h0);
      wait_ready("ready_latency_sweep");
      drive(1, 0, 6'd0, 8'h00, 1, 0, 6'd31, 8'h00);
      tick();
      chk("sweep_addr0", 32'(q_a), 32'h0);
      chk("sweep_addr31", 32'(q_b), 32'h0);
      drive(1, 0, 6'd63, 8'h00, 0, 0, 6'd0, 8'h00);
      tick();
      chk("sweep_addr63", 32'(q_a), 32'h0);

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].en_a, vecs[i].we_a, vecs[i].addr_a, vecs[i].data_a,
               vecs[i].en_b, vecs[i].we_b, vecs[i].addr_b, vecs[i].data_b);
         tick();
         if (vecs[i].chk_qa) chk($sformatf("vec%0d_q_a", i), 32'(q_a), 32'(vecs[i].exp_qa));
         if (vecs[i].chk_qb) chk($sformatf("vec%0d_q_b", i), 32'(q_b), 32'(vecs[i].exp_qb));
         chk($sformatf("vec%0d_collision", i), 32'(collision), 32'(vecs[i].exp_col));
         chk($sformatf("vec%0d_par_err", i), 32'({par_err_a, par_err_b}), 32'h0);
      end

      // Reset in the middle of the sweep restarts it from address 0.
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("midsweep_ready_low", 32'(ready), 32'h0);
      rst = 1'b1;
      tick();
      chk("midsweep_rst_ready", 32'(ready), 32'h0);
      wait_ready("ready_latency_midsweep");
      drive(1, 0, 6'd10, 8'h00, 1, 0, 6'd63, 8'h00);
      tick();
      chk("midsweep_addr10", 32'(q_a), 32'h0);
      chk("midsweep_addr63", 32'(q_b), 32'h0);

`ifdef DPRAM_PARITY_EN
      drive(1, 1, 6'd5, 8'h0F, 1, 1, 6'd6, 8'h03);
      tick();
      idle();
      dut.mem[5][0] = ~dut.mem[5][0];
      drive(1, 0, 6'd5, 8'h00, 0, 0, 6'd0, 8'h00);
      tick();
      chk("par_bad_q_a", 32'(q_a), 32'h0E);
      chk("par_bad_err", 32'(par_err_a), 32'h1);
      drive(1, 0, 6'd6, 8'h00, 0, 0, 6'd0, 8'h00);
      tick();
      chk("par_good_q_a", 32'(q_a), 32'h03);
      chk("par_good_err", 32'(par_err_a), 32'h0);
`endif

      idle();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
